// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one of NUM_REQ requesters a burst of up to MAX_BURST words into a FIFO.
// Latency: one IDLE arbitration cycle before each burst; data passes combinationally to the FIFO during GRANT.
// Backpressure: fifo_full drops the granted req_ready and stalls the burst indefinitely; the beat count is held.
module fifo_wr_arbiter #(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 8,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       fifo_w_en,
  output logic [WIDTH-1:0]           fifo_data_in,
  input  logic                       fifo_full,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int IDW  = $clog2(NUM_REQ);
  localparam int CNTW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IDW-1:0]  grant_nxt;
  logic [IDW-1:0]  last_winner;
  logic [IDW-1:0]  last_winner_nxt;
  logic [IDW-1:0]  rr_pick;
  logic            rr_found;
  logic [CNTW-1:0] beat_cnt;
  logic [CNTW-1:0] beat_cnt_nxt;
  logic            burst_done;

  // Circular search for the first valid requester after the previous winner.
  always_comb begin : rr_search
    int             idx;
    logic [IDW-1:0] cur;
    idx      = 0;
    cur      = '0;
    rr_pick  = '0;
    rr_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_winner) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cur = IDW'(idx);
      if (!rr_found && req_valid[cur]) begin
        rr_pick  = cur;
        rr_found = 1'b1;
      end
    end
  end

  // Datapath and handshake outputs; everything is zero outside a grant.
  always_comb begin
    busy         = (state == GRANT);
    req_ready    = '0;
    fifo_w_en    = 1'b0;
    fifo_data_in = '0;
    if (state == GRANT) begin
      req_ready[grant_id] = !fifo_full;
      fifo_w_en           = req_valid[grant_id] && !fifo_full;
      fifo_data_in        = req_data[int'(grant_id)*WIDTH +: WIDTH];
    end
  end

  // The burst ends on the marked last word or on the beat that reaches the cap.
  always_comb begin
    burst_done = req_last[grant_id] || (beat_cnt == CNTW'(MAX_BURST - 1));
  end

  // Next-state: arbitrate in IDLE, count beats and detect burst end in GRANT.
  always_comb begin
    state_nxt       = state;
    grant_nxt       = grant_id;
    beat_cnt_nxt    = beat_cnt;
    last_winner_nxt = last_winner;
    case (state)
      IDLE: begin
        if (rr_found) begin
          state_nxt    = GRANT;
          grant_nxt    = rr_pick;
          beat_cnt_nxt = '0;
        end
      end
      GRANT: begin
        if (!req_valid[grant_id]) begin
          // Holder ran dry: give the slot back immediately.
          state_nxt       = IDLE;
          last_winner_nxt = grant_id;
        end else if (fifo_w_en) begin
          beat_cnt_nxt = beat_cnt + CNTW'(1);
          if (burst_done) begin
            state_nxt       = IDLE;
            last_winner_nxt = grant_id;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State registers; reset makes requester 0 the first winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_id    <= '0;
      beat_cnt    <= '0;
      last_winner <= IDW'(NUM_REQ - 1);
    end else begin
      state       <= state_nxt;
      grant_id    <= grant_nxt;
      beat_cnt    <= beat_cnt_nxt;
      last_winner <= last_winner_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;
  localparam int D  = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           fifo_w_en;
  logic [W-1:0]   fifo_data_in;
  logic           fifo_full;
  logic [1:0]     grant_id;
  logic           busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.DEPTH(D), .WIDTH(W), .NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_w_en(fifo_w_en),
    .fifo_data_in(fifo_data_in), .fifo_full(fifo_full), .grant_id(grant_id),
    .busy(busy)
  );

  typedef struct packed { logic last; logic [W-1:0] dat; } word_t;
  typedef struct packed { logic [1:0] id; logic [W-1:0] dat; } wr_t;

  word_t        src_q[N][$];
  logic [W-1:0] exp_q[N][$];
  wr_t          fifo_q[$];
  wr_t          rd_log[$];
  int           grant_log[$];
  int           gap_log[$];
  int           blen_log[$];
  logic [N-1:0] vmask_sched[$];
  logic         full_sched[$];
  int           vmask_pct;
  int           drain_pct;

  // Transaction-level reference: who holds the FIFO, beats taken, previous winner.
  bit m_busy;
  int m_owner, m_beats, m_last;

  int n_vec, n_err;
  bit prev_busy;
  int idle_run;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_beats = 0; m_last = N - 1;
  endtask

  task automatic clear_logs();
    grant_log.delete(); gap_log.delete(); blen_log.delete();
    prev_busy = 0; idle_run = 0;
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 1;
    return 0;
  endfunction

  task automatic load_burst(input int r, input logic [W-1:0] base, input int len, input int last_at);
    word_t w;
    for (int k = 0; k < len; k++) begin
      w.dat = base + W'(k);
      w.last = (k == last_at);
      src_q[r].push_back(w);
      exp_q[r].push_back(w.dat);
    end
  endtask

  task automatic begin_test();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; req_last = '0; fifo_full = 1'b0;
    for (int i = 0; i < N; i++) begin src_q[i].delete(); exp_q[i].delete(); end
    fifo_q.delete(); rd_log.delete(); vmask_sched.delete(); full_sched.delete();
    vmask_pct = 100; drain_pct = 100;
    model_reset();
    clear_logs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive_inputs();
    logic [N-1:0] m;
    if (vmask_sched.size() > 0) m = vmask_sched.pop_front();
    else for (int i = 0; i < N; i++) m[i] = ($urandom_range(99) < vmask_pct);
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && m[i]) begin
        req_valid[i] = 1'b1;
        req_data[i*W +: W] = src_q[i][0].dat;
        req_last[i] = src_q[i][0].last;
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*W +: W] = W'($urandom);
        req_last[i] = 1'($urandom);
      end
    end
    if (full_sched.size() > 0) fifo_full = full_sched.pop_front();
    else fifo_full = (fifo_q.size() >= D);
  endtask

  // One clock: drive at the falling edge, compare just after, then advance model and sources.
  task automatic run_cycle();
    logic         exp_wen;
    logic [N-1:0] exp_rdy;
    logic [W-1:0] exp_dat;
    int           pick, idx;
    drive_inputs();
    #1;
    exp_rdy = '0; exp_wen = 1'b0; exp_dat = '0;
    if (m_busy) begin
      if (!fifo_full) exp_rdy[m_owner] = 1'b1;
      exp_wen = req_valid[m_owner] && !fifo_full;
      exp_dat = req_data[m_owner*W +: W];
    end
    n_vec++;
    if (busy !== m_busy) begin n_err++; $display("FAIL busy t=%0t got=%b want=%b", $time, busy, m_busy); end
    n_vec++;
    if (req_ready !== exp_rdy) begin n_err++; $display("FAIL req_ready t=%0t got=%b want=%b", $time, req_ready, exp_rdy); end
    n_vec++;
    if (fifo_w_en !== exp_wen) begin n_err++; $display("FAIL fifo_w_en t=%0t got=%b want=%b", $time, fifo_w_en, exp_wen); end
    n_vec++;
    if (fifo_data_in !== exp_dat) begin n_err++; $display("FAIL fifo_data_in t=%0t got=%h want=%h", $time, fifo_data_in, exp_dat); end
    if (m_busy) begin
      n_vec++;
      if (grant_id !== 2'(m_owner)) begin n_err++; $display("FAIL grant_id t=%0t got=%0d want=%0d", $time, grant_id, m_owner); end
    end
    // Burst bookkeeping from what the DUT actually did.
    if (busy) begin
      if (!prev_busy) begin grant_log.push_back(int'(grant_id)); gap_log.push_back(idle_run); blen_log.push_back(0); end
      if (fifo_w_en) blen_log[blen_log.size()-1] = blen_log[blen_log.size()-1] + 1;
      idle_run = 0;
    end else idle_run++;
    prev_busy = busy;
    if (fifo_w_en) fifo_q.push_back({grant_id, fifo_data_in});
    for (int i = 0; i < N; i++) if (req_valid[i] && exp_rdy[i]) void'(src_q[i].pop_front());
    if (fifo_q.size() > 0 && $urandom_range(99) < drain_pct) rd_log.push_back(fifo_q.pop_front());
    // Reference update from the arbitration rules.
    if (!m_busy) begin
      if (req_valid != '0) begin
        pick = -1;
        for (int k = 1; k <= N; k++) begin
          idx = (m_last + k) % N;
          if (pick < 0 && req_valid[idx]) pick = idx;
        end
        m_owner = pick; m_beats = 0; m_busy = 1;
      end
    end else if (!req_valid[m_owner]) begin
      m_busy = 0; m_last = m_owner;
    end else if (exp_wen) begin
      m_beats++;
      if (req_last[m_owner] || m_beats == MB) begin m_busy = 0; m_last = m_owner; end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Run until every source is drained, then check each requester's words arrived once, in order.
  task automatic run_until_done(input int budget, input string name);
    int c;
    logic [W-1:0] got[$];
    bit ok;
    c = 0;
    while ((pending() || m_busy) && c < budget) begin run_cycle(); c++; end
    n_vec++;
    if (pending() || m_busy) begin n_err++; $display("FAIL %s timeout after %0d cycles, required drain", name, c); end
    while (fifo_q.size() > 0) rd_log.push_back(fifo_q.pop_front());
    for (int i = 0; i < N; i++) begin
      got.delete();
      foreach (rd_log[k]) if (int'(rd_log[k].id) == i) got.push_back(rd_log[k].dat);
      ok = (got.size() == exp_q[i].size());
      if (ok) foreach (got[k]) if (got[k] !== exp_q[i][k]) ok = 0;
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL %s order req%0d got %0d words want %0d", name, i, got.size(), exp_q[i].size()); end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '1; req_last = '0; req_data = N*W'($urandom); fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_vec++; if (fifo_w_en !== 1'b0) begin n_err++; $display("FAIL reset_wen got=%b want=0", fifo_w_en); end
    n_vec++; if (req_ready !== '0) begin n_err++; $display("FAIL reset_ready got=%b want=0", req_ready); end
    n_vec++; if (fifo_data_in !== '0) begin n_err++; $display("FAIL reset_data got=%h want=0", fifo_data_in); end
    req_valid = '0; rst_n = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_hold got busy=%b want=0", busy); end
    req_valid = '1; fifo_full = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    n_vec++; if ({busy, grant_id} !== 3'b100) begin n_err++; $display("FAIL first_grant got busy=%b id=%0d want busy=1 id=0", busy, grant_id); end
    n_vec++; if ({req_ready, fifo_w_en} !== 5'b0) begin n_err++; $display("FAIL full_stall got rdy=%b wen=%b want 0", req_ready, fifo_w_en); end
    fifo_full = 1'b0; #1;
    n_vec++; if ({req_ready, fifo_w_en} !== 5'b00011) begin n_err++; $display("FAIL grant_rdy got rdy=%b wen=%b want 0001/1", req_ready, fifo_w_en); end
    n_vec++; if (fifo_data_in !== req_data[W-1:0]) begin n_err++; $display("FAIL grant_data got=%h want=%h", fifo_data_in, req_data[W-1:0]); end
  endtask

  task automatic test_round_robin();
    int exp_g[5];
    exp_g = '{0, 1, 2, 3, 0};
    begin_test();
    load_burst(0, 8'h00, 2, 1); load_burst(0, 8'h02, 2, 1);
    load_burst(1, 8'h10, 2, 1); load_burst(2, 8'h20, 2, 1); load_burst(3, 8'h30, 2, 1);
    run_until_done(200, "round_robin");
    n_vec++;
    if (grant_log.size() != 5) begin n_err++; $display("FAIL rr_count got=%0d want=5", grant_log.size()); end
    else for (int k = 0; k < 5; k++) begin
      n_vec++; if (grant_log[k] != exp_g[k]) begin n_err++; $display("FAIL rr_order[%0d] got=%0d want=%0d", k, grant_log[k], exp_g[k]); end
      n_vec++; if (blen_log[k] != 2) begin n_err++; $display("FAIL rr_len[%0d] got=%0d want=2", k, blen_log[k]); end
      if (k > 0) begin
        n_vec++; if (gap_log[k] != 1) begin n_err++; $display("FAIL rr_gap[%0d] got=%0d want=1", k, gap_log[k]); end
      end
    end
  endtask

  task automatic test_max_burst();
    begin_test();
    load_burst(2, 8'h20, 6, -1);
    run_until_done(200, "max_burst");
    n_vec++;
    if (grant_log.size() != 2 || grant_log[0] != 2 || grant_log[1] != 2 || blen_log[0] != MB || blen_log[1] != 2 || gap_log[1] != 1) begin
      n_err++; $display("FAIL max_burst grants=%0d lens=%p gap=%p want ids 2,2 lens 4,2 gap 1", grant_log.size(), blen_log, gap_log);
    end
  endtask

  task automatic test_backpressure();
    begin_test();
    load_burst(1, 8'h10, 4, 3);
    full_sched = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    run_until_done(200, "backpressure");
    n_vec++;
    if (grant_log.size() != 1 || blen_log[0] != 4) begin
      n_err++; $display("FAIL bp_burst grants=%0d lens=%p want one burst of 4", grant_log.size(), blen_log);
    end
    n_vec++;
    if (rd_log.size() != 4 || rd_log[0].dat !== 8'h10 || rd_log[1].dat !== 8'h11 || rd_log[2].dat !== 8'h12 || rd_log[3].dat !== 8'h13) begin
      n_err++; $display("FAIL bp_words got %0d words want 10,11,12,13", rd_log.size());
    end
  endtask

  task automatic test_alternating();
    logic [W-1:0] e;
    int blk;
    begin_test();
    load_burst(0, 8'hA0, 8, 7);
    load_burst(3, 8'hD0, 8, 7);
    drain_pct = 50;
    run_until_done(400, "alternating");
    n_vec++;
    if (rd_log.size() != 16) begin n_err++; $display("FAIL alt_count got=%0d want=16", rd_log.size()); end
    else for (int k = 0; k < 16; k++) begin
      blk = k / 4;
      e = ((blk % 2) == 0 ? 8'hA0 : 8'hD0) + W'((blk / 2) * 4 + (k % 4));
      n_vec++;
      if (rd_log[k].dat !== e) begin n_err++; $display("FAIL alt_read[%0d] got=%h want=%h", k, rd_log[k].dat, e); end
    end
  endtask

  task automatic test_reset_midburst();
    begin_test();
    load_burst(0, 8'h00, 2, 1);
    load_burst(1, 8'h10, 4, 3);
    vmask_sched = '{4'b0010, 4'b0010};
    run_cycle();
    run_cycle();
    drive_inputs(); #1;
    n_vec++;
    if ({busy, grant_id, fifo_w_en} !== 4'b1011) begin n_err++; $display("FAIL mid_beat2 got busy=%b id=%0d wen=%b want 1/1/1", busy, grant_id, fifo_w_en); end
    rst_n = 1'b0; #1;
    n_vec++;
    if ({busy, fifo_w_en, req_ready, fifo_data_in} !== '0) begin
      n_err++; $display("FAIL mid_abort got busy=%b wen=%b rdy=%b data=%h want all 0", busy, fifo_w_en, req_ready, fifo_data_in);
    end
    model_reset();
    clear_logs();
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    run_until_done(200, "reset_midburst");
    n_vec++;
    if (grant_log.size() == 0 || grant_log[0] != 0) begin n_err++; $display("FAIL mid_regrant got first=%0d want=0", grant_log.size() ? grant_log[0] : -1); end
  endtask

  task automatic test_valid_drop();
    begin_test();
    load_burst(2, 8'h20, 3, -1);
    load_burst(3, 8'h30, 2, 1);
    vmask_sched = '{4'b1111, 4'b1111, 4'b1011};
    run_until_done(200, "valid_drop");
    n_vec++;
    if (grant_log.size() != 3 || grant_log[0] != 2 || grant_log[1] != 3 || grant_log[2] != 2) begin
      n_err++; $display("FAIL drop_order got=%p want 2,3,2", grant_log);
    end
    n_vec++;
    if (blen_log.size() != 3 || blen_log[0] != 1 || blen_log[1] != 2 || blen_log[2] != 2 || gap_log[1] != 1) begin
      n_err++; $display("FAIL drop_lens got=%p gaps=%p want 1,2,2 gap 1", blen_log, gap_log);
    end
  endtask

  task automatic test_random();
    int len;
    for (int round = 0; round < 4; round++) begin
      begin_test();
      vmask_pct = 80;
      drain_pct = 40;
      for (int r = 0; r < N; r++)
        for (int b = 0; b < int'($urandom_range(3, 1)); b++) begin
          len = $urandom_range(10, 1);
          load_burst(r, W'($urandom), len, ($urandom_range(3) == 0) ? -1 : len - 1);
        end
      run_until_done(3000, "random");
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    vmask_pct = 100; drain_pct = 100;
    model_reset();
    clear_logs();
    test_reset();
    test_round_robin();
    test_max_burst();
    test_backpressure();
    test_alternating();
    test_reset_midburst();
    test_valid_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DEPTH, default 8, depth of the downstream synchronous FIFO (informational, sizes no logic here).
REQ-002 Parameter WIDTH, default 8, data word width.
REQ-003 Parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-004 Parameter MAX_BURST, default 4, maximum beats per grant (1..16).
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 req_valid  in  NUM_REQ  per-requester word-available flag.
REQ-008 req_data  in  NUM_REQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
REQ-009 req_last  in  NUM_REQ  marks the final word of requester i's burst.
REQ-010 req_ready  out  NUM_REQ  word of requester i accepted this cycle when req_valid[i] and req_ready[i] are both high.
REQ-011 fifo_w_en  out  1  write strobe to FIFO w_en.
REQ-012 fifo_data_in  out  WIDTH  data to FIFO data_in.
REQ-013 fifo_full  in  1  FIFO full flag.
REQ-014 grant_id  out  $clog2(NUM_REQ)  index of current grant holder, valid while busy is high.
REQ-015 busy  out  1  high in GRANT state.

Function
REQ-016 The FSM SHALL have two states, IDLE and GRANT, with registered state, grant_id, last-winner pointer and beat counter.
REQ-017 In IDLE with any req_valid high, the block SHALL select the first valid requester in circular order starting at (last_winner+1) mod NUM_REQ, load grant_id, clear the beat counter, and enter GRANT next cycle; req_ready stays all-zero in IDLE.
REQ-018 In IDLE with no req_valid high, the block SHALL remain in IDLE.
REQ-019 In GRANT, req_ready[grant_id] SHALL equal !fifo_full combinationally, and all other req_ready bits SHALL be 0.
REQ-020 In GRANT, fifo_w_en SHALL equal req_valid[grant_id] && !fifo_full, and fifo_data_in SHALL equal the grant_id slice of req_data; in IDLE fifo_w_en SHALL be 0 and fifo_data_in 0.
REQ-021 The beat counter SHALL increment by 1 on each cycle with fifo_w_en high.
REQ-022 GRANT SHALL exit to IDLE after a write beat with req_last[grant_id] high, or after the write beat bringing the counter to MAX_BURST.
REQ-023 GRANT SHALL exit to IDLE on any cycle where req_valid[grant_id] is low (no write that cycle).
REQ-024 With fifo_full high and req_valid[grant_id] high, the block SHALL stay in GRANT with counter held and no write (back-pressure stall, no timeout).
REQ-025 On every exit from GRANT, last_winner SHALL be loaded with grant_id.
REQ-026 Minimum spacing between bursts SHALL be one IDLE arbitration cycle; a burst of B beats with no stalls SHALL occupy B+1 cycles from IDLE to IDLE.
REQ-027 req_valid changes of non-granted requesters SHALL have no effect during GRANT.

Reset
REQ-028 While rst_n is low: state IDLE, grant_id 0, beat counter 0, last_winner NUM_REQ-1 (requester 0 wins first), busy 0, fifo_w_en 0, fifo_data_in 0, req_ready all 0.
REQ-029 Reset asserted mid-burst SHALL abort the burst immediately with no further FIFO write; after release the block SHALL start arbitration from IDLE with requester 0 highest priority.

Verification
REQ-030 After reset, req_valid=4'b1111, each burst 2 words with req_last on word 2, FIFO not full -> grants in order 0,1,2,3,0; each burst = 2 writes + 1 IDLE cycle.
REQ-031 Requester 2 alone, 6 valid words, req_last never high, MAX_BURST=4 -> 4 writes, 1 IDLE cycle, re-grant of 2, remaining 2 words written.
REQ-032 Requester 1 granted, fifo_full forced high 3 cycles mid-burst -> req_ready[1]=0, fifo_w_en=0, counter held; resumes with no lost or duplicated word.
REQ-033 Requesters 0 and 3 valid, 8-word bursts of data 8'hA0.. and 8'hD0.., DEPTH=8 FIFO drained in parallel -> FIFO read order shows 4-word alternating bursts, no reordering within a requester.
REQ-034 rst_n pulsed low during beat 2 of requester 1 -> fifo_w_en low at once, busy 0; after release requester 0 (if valid) granted first.
REQ-035 Granted requester drops req_valid after 1 word with no req_last -> GRANT exits that cycle, next valid requester granted after one IDLE cycle.
